// File: rtl/multi_edge_pulser.sv
// multi_edge_pulser: N-channel edge detector and fixed-width pulse extender
// with per-channel edge selection, optional retrigger and saturating counters.
//
// Parameters:
//   CHANNELS    number of independent channels (1..16)
//   PULSE_EXT   output pulse width in clk cycles (>=1)
//   SYNC_STAGES synchroniser depth when MULTI_EDGE_SYNC_EN is defined (2..4)
//   RETRIGGER   0: edges during a pulse are dropped
//               1: an edge during a pulse reloads the width counter
//
// Ports:
//   clk        fabric clock
//   rst        synchronous active-high reset
//   signal_in  [CHANNELS]   input lines
//   edge_type  [2*CHANNELS] per-channel mode at [2i+1:2i]
//              00 off, 01 rising, 10 falling, 11 both
//   count_clr  synchronous clear of all event counters (wins over increment)
//   pulse_out  [CHANNELS]   registered extended pulses
//   event_cnt  [8*CHANNELS] saturating accepted-edge counters at [8i+7:8i]
//
// Build option:
//   MULTI_EDGE_SYNC_EN  defined: input stage is a SYNC_STAGES-deep
//                       synchroniser, signal_in may be asynchronous.
//                       undefined: input stage is one flop, signal_in
//                       must already be synchronous to clk.

module multi_edge_pulser #(
   parameter int CHANNELS    = 3,
   parameter int PULSE_EXT   = 6,
   parameter int SYNC_STAGES = 2,
   parameter int RETRIGGER   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   signal_in,
   input  logic [2*CHANNELS-1:0] edge_type,
   input  logic                  count_clr,
   output logic [CHANNELS-1:0]   pulse_out,
   output logic [8*CHANNELS-1:0] event_cnt
);

   // ------------------------------------------------------------------
   // Derived sizes
   // ------------------------------------------------------------------
`ifdef MULTI_EDGE_SYNC_EN
   localparam int DEPTH = SYNC_STAGES;
`else
   localparam int DEPTH = 1;
`endif

   // Detection stays disarmed until the input stage and the history flop
   // have both been refilled from live input after reset.
   localparam int WARM_LEN = DEPTH + 1;

   // Warm-up counter is sized for the deepest synchroniser so both builds
   // share one layout.
   localparam int WW = $clog2(SYNC_STAGES + 2);
   localparam logic [WW-1:0] WARM_END = WW'(WARM_LEN);

   // Width counter; a one-cycle pulse still needs a 1-bit holder.
   localparam int CW = (PULSE_EXT > 1) ? $clog2(PULSE_EXT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_EXT - 1);

   localparam logic [7:0] EVT_MAX = 8'hFF;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
`ifdef MULTI_EDGE_SYNC_EN
   (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS", async_reg = "true" *)
`endif
   logic [CHANNELS-1:0][DEPTH-1:0] sync_q;
   logic [CHANNELS-1:0][DEPTH-1:0] sync_d;

   logic [CHANNELS-1:0]            prev_q;
   logic [CHANNELS-1:0]            prev_d;

   logic [CHANNELS-1:0][CW-1:0]    cnt_q;
   logic [CHANNELS-1:0][CW-1:0]    cnt_d;

   logic [CHANNELS-1:0]            pulse_q;
   logic [CHANNELS-1:0]            pulse_d;

   logic [CHANNELS-1:0][7:0]       evt_q;
   logic [CHANNELS-1:0][7:0]       evt_d;

   logic [WW-1:0]                  wu_q;
   logic [WW-1:0]                  wu_d;

   // ------------------------------------------------------------------
   // Combinational intermediates
   // ------------------------------------------------------------------
   logic                           armed;
   logic [CHANNELS-1:0]            s_last;
   logic [CHANNELS-1:0]            rise;
   logic [CHANNELS-1:0]            fall;
   logic [CHANNELS-1:0]            det;
   logic [CHANNELS-1:0]            accept;

   // ------------------------------------------------------------------
   // Warm-up: counts up once after reset and then holds
   // ------------------------------------------------------------------
   always_comb begin
      wu_d = wu_q;
      if (wu_q != WARM_END) begin
         wu_d = wu_q + 1'b1;
      end
   end

   assign armed = (wu_q == WARM_END);

   // ------------------------------------------------------------------
   // Input stage and history
   // ------------------------------------------------------------------
   always_comb begin
      sync_d = sync_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
`ifdef MULTI_EDGE_SYNC_EN
         sync_d[ch] = {sync_q[ch][DEPTH-2:0], signal_in[ch]};
`else
         sync_d[ch] = signal_in[ch];
`endif
      end
   end

   always_comb begin
      s_last = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         s_last[ch] = sync_q[ch][DEPTH-1];
      end
   end

   assign prev_d = s_last;

   // ------------------------------------------------------------------
   // Edge detection
   // ------------------------------------------------------------------
   always_comb begin
      rise = '0;
      fall = '0;
      det  = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         rise[ch] = s_last[ch] & ~prev_q[ch];
         fall[ch] = ~s_last[ch] & prev_q[ch];
         det[ch]  = armed &
                    ((edge_type[2*ch]   & rise[ch]) |
                     (edge_type[2*ch+1] & fall[ch]));
      end
   end

   // ------------------------------------------------------------------
   // Pulse extender
   // ------------------------------------------------------------------
   always_comb begin
      pulse_d = pulse_q;
      cnt_d   = cnt_q;
      accept  = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (!pulse_q[ch]) begin
            if (det[ch]) begin
               pulse_d[ch] = 1'b1;
               cnt_d[ch]   = CNT_LOAD;
               accept[ch]  = 1'b1;
            end
         end else begin
            // A retriggering edge also covers the final cycle, so the
            // output never shows a gap between overlapping pulses.
            if ((RETRIGGER != 0) && det[ch]) begin
               cnt_d[ch]  = CNT_LOAD;
               accept[ch] = 1'b1;
            end else if (cnt_q[ch] != '0) begin
               cnt_d[ch] = cnt_q[ch] - 1'b1;
            end else begin
               pulse_d[ch] = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Event counters
   // ------------------------------------------------------------------
   always_comb begin
      evt_d = evt_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (count_clr) begin
            evt_d[ch] = '0;
         end else if (accept[ch] && (evt_q[ch] != EVT_MAX)) begin
            evt_d[ch] = evt_q[ch] + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         pulse_q <= '0;
         evt_q   <= '0;
         wu_q    <= '0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         evt_q   <= evt_d;
         wu_q    <= wu_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pulse_out = pulse_q;
   assign event_cnt = evt_q;

endmodule

// File: tb/tb_multi_edge_pulser.sv
// Testbench for multi_edge_pulser: table-driven edge modes, directed
// corner sequences, and a per-cycle queue scoreboard over two instances.

module tb_multi_edge_pulser;

   localparam int CH = 3;
   localparam int PW = 6;
   localparam int SS = 2;
`ifdef MULTI_EDGE_SYNC_EN
   localparam int DEPTH = SS;
`else
   localparam int DEPTH = 1;
`endif
   localparam int LAT  = DEPTH + 1;
   localparam int WARM = DEPTH + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [CH-1:0]    signal_in;
   logic [2*CH-1:0]  edge_type;
   logic             count_clr;
   logic [CH-1:0]    pulse0;
   logic [CH-1:0]    pulse1;
   logic [8*CH-1:0]  cnt0;
   logic [8*CH-1:0]  cnt1;

   multi_edge_pulser #(
      .CHANNELS(CH), .PULSE_EXT(PW), .SYNC_STAGES(SS), .RETRIGGER(0)
   ) u_dut (
      .clk(clk), .rst(rst), .signal_in(signal_in), .edge_type(edge_type),
      .count_clr(count_clr), .pulse_out(pulse0), .event_cnt(cnt0)
   );

   multi_edge_pulser #(
      .CHANNELS(CH), .PULSE_EXT(PW), .SYNC_STAGES(SS), .RETRIGGER(1)
   ) u_rt (
      .clk(clk), .rst(rst), .signal_in(signal_in), .edge_type(edge_type),
      .count_clr(count_clr), .pulse_out(pulse1), .event_cnt(cnt1)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [CH-1:0]   p0;
      logic [8*CH-1:0] c0;
      logic [CH-1:0]   p1;
      logic [8*CH-1:0] c1;
   } exp_t;

   exp_t          sbq[$];
   int            rem [2][CH];
   int            mc  [2][CH];
   logic [CH-1:0] sh  [0:4];
   int            nedge;

   // m=0 drops edges while a pulse is showing, m=1 restarts the window.
   task automatic model_step();
      exp_t          e;
      logic [CH-1:0] sl;
      logic [CH-1:0] pv;
      logic [1:0]    md;
      bit            d;
      bit            acc;
      if (rst) begin
         nedge = 0;
         for (int j = 0; j < 5; j++) sh[j] = '0;
         for (int m = 0; m < 2; m++)
            for (int c = 0; c < CH; c++) begin
               rem[m][c] = 0;
               mc[m][c]  = 0;
            end
      end else begin
         nedge++;
         sl = sh[DEPTH-1];
         pv = sh[DEPTH];
         for (int m = 0; m < 2; m++)
            for (int c = 0; c < CH; c++) begin
               md  = edge_type[2*c +: 2];
               d   = (nedge > WARM) &&
                     ((md[0] && sl[c] && !pv[c]) ||
                      (md[1] && !sl[c] && pv[c]));
               acc = d && (m == 1 || rem[m][c] == 0);
               if (acc) rem[m][c] = PW;
               else if (rem[m][c] > 0) rem[m][c]--;
               if (count_clr) mc[m][c] = 0;
               else if (acc && mc[m][c] < 255) mc[m][c]++;
            end
         for (int j = 4; j > 0; j--) sh[j] = sh[j-1];
         sh[0] = signal_in;
      end
      for (int c = 0; c < CH; c++) begin
         e.p0[c]       = (rem[0][c] > 0);
         e.p1[c]       = (rem[1][c] > 0);
         e.c0[8*c +: 8] = 8'(mc[0][c]);
         e.c1[8*c +: 8] = 8'(mc[1][c]);
      end
      sbq.push_back(e);
   endtask

   int            rise0 [CH];
   int            rise1 [CH];
   int            hi0   [CH];
   int            hi1   [CH];
   logic [CH-1:0] last0 = '0;
   logic [CH-1:0] last1 = '0;

   task automatic clear_tally();
      for (int c = 0; c < CH; c++) begin
         rise0[c] = 0; rise1[c] = 0; hi0[c] = 0; hi1[c] = 0;
      end
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      model_step();
      @(negedge clk);
      e = sbq.pop_front();
      check("sb_pulse",    32'(pulse0), 32'(e.p0));
      check("sb_cnt",      32'(cnt0),   32'(e.c0));
      check("sb_pulse_rt", 32'(pulse1), 32'(e.p1));
      check("sb_cnt_rt",   32'(cnt1),   32'(e.c1));
      for (int c = 0; c < CH; c++) begin
         rise0[c] += int'(pulse0[c] && !last0[c]);
         rise1[c] += int'(pulse1[c] && !last1[c]);
         hi0[c]   += int'(pulse0[c]);
         hi1[c]   += int'(pulse1[c]);
      end
      last0 = pulse0;
      last1 = pulse1;
   endtask

   // ---------------- edge-mode vector table ----------------
   typedef struct {
      int         ch;
      logic [1:0] mode;
      logic       from_lv;
      logic       to_lv;
      logic       exp_p;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int rise_at;
      int width;
      int seen0;
      int seen1;

      vecs[0] = '{0, 2'b01, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{0, 2'b01, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1, 2'b10, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1, 2'b10, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{2, 2'b11, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{2, 2'b11, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{0, 2'b00, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1, 2'b00, 1'b1, 1'b0, 1'b0};

      rst       = 1'b1;
      signal_in = '0;
      edge_type = 6'b010101;
      count_clr = 1'b0;
      clear_tally();

      // reset state
      repeat (3) step();
      check("reset_pulse",  32'(pulse0), 0);
      check("reset_cnt",    32'(cnt0),   0);
      check("reset_cnt_rt", 32'(cnt1),   0);

      // isolated rising edge on ch0
      rst = 1'b0;
      repeat (10) step();
      clear_tally();
      signal_in[0] = 1'b1;
      rise_at = -1;
      width   = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (pulse0[0]) begin
            if (rise_at < 0) rise_at = i;
            width++;
         end
      end
      check("t1_latency", rise_at, LAT);
      check("t1_width",   width,   PW);
      check("t1_cnt0",    32'(cnt0[7:0]),  1);
      check("t1_cnt_oth", 32'(cnt0[23:8]), 0);
      check("t1_oth_pulse", rise0[1] + rise0[2], 0);

      // levels present at reset
      rst       = 1'b1;
      signal_in = 3'b111;
      edge_type = 6'b111111;
      repeat (3) step();
      rst = 1'b0;
      clear_tally();
      repeat (15) step();
      check("t2_no_pulse",    rise0[0] + rise0[1] + rise0[2], 0);
      check("t2_no_pulse_rt", rise1[0] + rise1[1] + rise1[2], 0);
      check("t2_cnt",    32'(cnt0), 0);
      check("t2_cnt_rt", 32'(cnt1), 0);

      // table of edge modes
      for (int v = 0; v < 8; v++) begin
         edge_type            = '0;
         signal_in[vecs[v].ch] = vecs[v].from_lv;
         count_clr            = 1'b1;
         step();
         count_clr = 1'b0;
         repeat (8) step();
         edge_type[2*vecs[v].ch +: 2] = vecs[v].mode;
         step();
         signal_in[vecs[v].ch] = vecs[v].to_lv;
         seen0 = 0;
         seen1 = 0;
         repeat (LAT + PW + 3) begin
            step();
            if (pulse0[vecs[v].ch]) seen0 = 1;
            if (pulse1[vecs[v].ch]) seen1 = 1;
         end
         check($sformatf("vec%0d_pulse", v),    seen0, 32'(vecs[v].exp_p));
         check($sformatf("vec%0d_pulse_rt", v), seen1, 32'(vecs[v].exp_p));
         check($sformatf("vec%0d_cnt", v),
               32'(cnt0[8*vecs[v].ch +: 8]), 32'(vecs[v].exp_p));
      end

      // toggling every 3 cycles: drop vs retrigger
      edge_type = 6'b001100;
      signal_in = '0;
      rst       = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (8) step();
      clear_tally();
      for (int i = 0; i < 10; i++) begin
         signal_in[1] = ~signal_in[1];
         repeat (3) step();
      end
      repeat (12) step();
      check("t4_cnt",      32'(cnt0[15:8]), 4);
      check("t4_cnt_rt",   32'(cnt1[15:8]), 10);
      check("t4_rises",    rise0[1], 4);
      check("t4_high",     hi0[1],   4 * PW);
      check("t4_rises_rt", rise1[1], 1);
      check("t4_high_rt",  hi1[1],   27 + PW);

      // 300 isolated edges on ch2, clear on the 300th
      edge_type = 6'b010000;
      signal_in = '0;
      count_clr = 1'b1;
      step();
      count_clr = 1'b0;
      repeat (8) step();
      for (int k = 1; k <= 300; k++) begin
         signal_in[2] = 1'b1;
         for (int j = 1; j <= 4; j++) begin
            count_clr = (k == 300) && (j == LAT);
            step();
         end
         count_clr    = 1'b0;
         signal_in[2] = 1'b0;
         repeat (4) step();
         if (k == 254) check("t5_cnt254", 32'(cnt0[23:16]), 254);
         if (k == 255) check("t5_cnt255", 32'(cnt0[23:16]), 255);
         if (k == 299) check("t5_sat",    32'(cnt0[23:16]), 255);
         if (k == 300) check("t5_clr",    32'(cnt0[23:16]), 0);
      end
      check("t5_clr_rt", 32'(cnt1[23:16]), 0);

      // mode switched off mid-pulse
      edge_type = 6'b000001;
      signal_in = '0;
      count_clr = 1'b1;
      step();
      count_clr = 1'b0;
      repeat (8) step();
      clear_tally();
      signal_in[0] = 1'b1;
      repeat (LAT) step();
      check("t6_started", 32'(pulse0[0]), 1);
      step();
      edge_type[1:0] = 2'b00;
      width = 2;
      repeat (10) begin
         step();
         if (pulse0[0]) width++;
      end
      check("t6_width", width, PW);
      signal_in[0] = 1'b0;
      repeat (4) step();
      signal_in[0] = 1'b1;
      repeat (12) step();
      check("t6_rises", rise0[0], 1);
      check("t6_cnt",   32'(cnt0[7:0]), 1);

      // reset asserted mid-pulse
      edge_type    = 6'b010101;
      signal_in[0] = 1'b0;
      repeat (8) step();
      signal_in[0] = 1'b1;
      repeat (LAT + 1) step();
      check("t7_pulse_on", 32'(pulse0[0]), 1);
      rst = 1'b1;
      step();
      check("t7_pulse_off", 32'(pulse0[0]), 0);
      check("t7_cnt_clr",   32'(cnt0),      0);
      rst = 1'b0;
      clear_tally();
      repeat (12) step();
      check("t7_no_rewarm", rise0[0] + rise0[1] + rise0[2], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
